// File: rtl/sqrt_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_datapath
//  Purpose  : Restoring digit-by-digit integer square-root datapath executing
//             ld / sh / ld_tmp / lda2 / r0 micro-ops from an external sequencer.
//  Options  : SQRT_DP_REMAINDER_EN exports the partial remainder port.
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt_datapath #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     radicand,
  input  logic                 ld,
  input  logic                 sh,
  input  logic                 ld_tmp,
  input  logic                 lda2,
  input  logic                 r0,
  output logic                 z,
  output logic                 msb,
  output logic [WIDTH/2-1:0]   result
`ifdef SQRT_DP_REMAINDER_EN
  ,
  output logic [WIDTH/2:0]     remainder
`endif
);

  localparam int RW = WIDTH / 2;
  localparam int CW = $clog2(RW) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RW);

  logic [WIDTH-1:0] a_q,   a_d;
  logic [RW+1:0]    a2_q,  a2_d;
  logic [RW+2:0]    tmp_q, tmp_d;
  logic [RW-1:0]    r_q,   r_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    a2_d  = a2_q;
    tmp_d = tmp_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    if (ld) begin
      a_d   = radicand;
      a2_d  = '0;
      tmp_d = '0;
      r_d   = '0;
      cnt_d = CNT_INIT;
    end else begin
      if (sh) begin
        {a2_d, a_d} = {a2_q[RW-1:0], a_q, 2'b00};
        r_d         = {r_q[RW-2:0], 1'b0};
        cnt_d       = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end else begin
        if (lda2) a2_d = tmp_q[RW+1:0];
        if (r0)   r_d[0] = 1'b1;
      end
      // R has already been shifted by sh, so {R,1} is {previous root, 2'b01}.
      if (ld_tmp) tmp_d = {1'b0, a2_q} - {2'b00, r_q, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      a2_q  <= '0;
      tmp_q <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      a2_q  <= a2_d;
      tmp_q <= tmp_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end

  assign z      = (cnt_q == '0);
  assign msb    = tmp_q[RW+2];
  assign result = r_q;
`ifdef SQRT_DP_REMAINDER_EN
  assign remainder = a2_q[RW:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqrt_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_datapath
//  Purpose  : Self-checking bench for sqrt_datapath (vector table, random
//             radicands against an arithmetic reference, corner sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_datapath;

  localparam int WIDTH = 16;
  localparam int RW    = WIDTH / 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   radicand;
  logic          ld, sh, ld_tmp, lda2, r0;
  logic          z, msb;
  logic [7:0]    result;
`ifdef SQRT_DP_REMAINDER_EN
  logic [8:0]    remainder;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] rad;
    int unsigned root;
    int unsigned rem;
  } vec_t;

  vec_t vecs[9];

  sqrt_datapath #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .radicand (radicand),
    .ld       (ld),
    .sh       (sh),
    .ld_tmp   (ld_tmp),
    .lda2     (lda2),
    .r0       (r0),
    .z        (z),
    .msb      (msb),
    .result   (result)
`ifdef SQRT_DP_REMAINDER_EN
    ,
    .remainder(remainder)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given strobes, then strobes drop and outputs are sampled.
  task automatic cyc(input logic l, input logic s, input logic t, input logic a, input logic r);
    ld = l; sh = s; ld_tmp = t; lda2 = a; r0 = r;
    @(posedge clk);
    #1;
    ld = 1'b0; sh = 1'b0; ld_tmp = 1'b0; lda2 = 1'b0; r0 = 1'b0;
  endtask

  function automatic int unsigned isqrt(input int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Sequencer-style iterations; digit i of the root is the expected trial sign.
  task automatic iterate(input string tag, input int unsigned exp_root, input int unsigned exp_rem);
    for (int i = 0; i < RW; i++) begin
      cyc(0, 1, 0, 0, 0);
      check({tag, " z"}, z, (i == RW - 1));
      cyc(0, 0, 1, 0, 0);
      check({tag, " msb"}, msb, (exp_root[RW-1-i] == 1'b0));
      if (msb == 1'b0) cyc(0, 0, 0, 1, 1);
    end
    check({tag, " result"}, result, exp_root);
`ifdef SQRT_DP_REMAINDER_EN
    check({tag, " remainder"}, remainder, exp_rem);
`else
    if (exp_rem > 2 * exp_root) check({tag, " rem model"}, exp_rem, 2 * exp_root);
`endif
  endtask

  task automatic run(input string tag, input logic [15:0] rad, input int unsigned exp_root,
                     input int unsigned exp_rem);
    radicand = rad;
    cyc(1, 0, 0, 0, 0);
    check({tag, " z after ld"}, z, 0);
    iterate(tag, exp_root, exp_rem);
  endtask

  initial begin
    logic [15:0] vrad;
    int unsigned vroot;

    vecs[0] = '{16'd144,   12,  0};
    vecs[1] = '{16'hFFFF,  255, 510};
    vecs[2] = '{16'd2,     1,   1};
    vecs[3] = '{16'd0,     0,   0};
    vecs[4] = '{16'd1000,  31,  39};
    vecs[5] = '{16'd1,     1,   0};
    vecs[6] = '{16'd3,     1,   2};
    vecs[7] = '{16'hFFFE,  255, 509};
    vecs[8] = '{16'd65024, 254, 508};

    rst = 1'b1; radicand = '0;
    ld = 1'b0; sh = 1'b0; ld_tmp = 1'b0; lda2 = 1'b0; r0 = 1'b0;
    #3;
    check("reset z", z, 1);
    check("reset msb", msb, 0);
    check("reset result", result, 0);
`ifdef SQRT_DP_REMAINDER_EN
    check("reset remainder", remainder, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 9; k++)
      run($sformatf("vec%0d", k), vecs[k].rad, vecs[k].root, vecs[k].rem);

    for (int k = 0; k < 20; k++) begin
      vrad  = 16'($urandom_range(0, 65535));
      vroot = isqrt(32'(vrad));
      run($sformatf("rand%0d(%0d)", k, vrad), vrad, vroot, 32'(vrad) - vroot * vroot);
    end

    // Asynchronous reset after the 3rd sh of radicand 1000.
    radicand = 16'd1000;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("midrst z before", z, 0);
    check("midrst msb before", msb, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst z", z, 1);
    check("midrst msb", msb, 0);
    check("midrst result", result, 0);
    rst = 1'b0;
    run("rerun1000", 16'd1000, 31, 39);

    cyc(0, 1, 0, 0, 0);
    check("extra sh z 1", z, 1);
    cyc(0, 1, 0, 0, 0);
    check("extra sh z 2", z, 1);

    // ld coincident with sh: load only, full 8 iterations remain.
    radicand = 16'd81;
    cyc(1, 1, 0, 0, 0);
    check("ldsh z", z, 0);
    iterate("ldsh81", 9, 0);

    // sh coincident with r0 and lda2: only the shift happens.
    radicand = 16'h4000;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("shr0 first msb", msb, 0);
    cyc(0, 1, 0, 1, 1);
    check("shr0 result", result, 0);
`ifdef SQRT_DP_REMAINDER_EN
    check("shr0 remainder", remainder, 4);
`endif
    cyc(0, 0, 1, 0, 0);
    check("shr0 trial msb", msb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
